// File: rtl/mil_txd_fifo.sv
// rtl/mil_txd_fifo.sv - MIL-STD-1553 Manchester-II word transmitter with word FIFO and message sequencing
module mil_txd_fifo #(
  parameter int FCLK     = 50_000_000,
  parameter int BITRATE  = 1_000_000,
  parameter int DEPTH    = 32,
  parameter int GAP_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [16:0]              wr_data,
  input  logic                     tx_start,
  output logic                     txp,
  output logic                     txn,
  output logic                     tx_en,
  output logic                     busy,
  output logic                     word_done,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf
);

  localparam int DIV    = FCLK / (2 * BITRATE);
  localparam int DW     = $clog2(DIV);
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int GAP_HB = 2 * GAP_BITS;
  localparam int HW     = (GAP_HB > 32) ? $clog2(GAP_HB) : 5;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PARITY, S_GAP} state_t;

  state_t          state, state_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic            load;
  logic            done_n;
  logic            pending;
  logic [16:0]     word_q, word_n;
  logic            txp_n, txn_n;
  logic            first_half, bit_val;

  logic [16:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            wr_ok;
  logic [CW-1:0]   count_n;

  assign tick  = (div_cnt == DW'(DIV - 1));
  assign wr_ok = wr_en && ((fifo_count != CW'(DEPTH)) || load);

  // Next-state sequencing: half-bit counting inside SYNC/DATA/PARITY/GAP, word loads (FIFO pops)
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    load    = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if ((tx_start || pending) && (fifo_count != '0)) begin
          load    = 1'b1;
          state_n = S_SYNC;
          hcnt_n  = '0;
        end
      end
      S_SYNC: begin
        if (tick) begin
          if (hcnt == HW'(5)) begin
            state_n = S_DATA;
            hcnt_n  = '0;
          end else begin
            hcnt_n = hcnt + HW'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (hcnt == HW'(31)) begin
            state_n = S_PARITY;
            hcnt_n  = '0;
          end else begin
            hcnt_n = hcnt + HW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (hcnt == HW'(1)) begin
            done_n = 1'b1;
            hcnt_n = '0;
            if (fifo_count != '0) begin
              load    = 1'b1;
              state_n = S_SYNC;
            end else begin
              state_n = S_GAP;
            end
          end else begin
            hcnt_n = hcnt + HW'(1);
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (hcnt == HW'(GAP_HB - 1)) begin
            state_n = S_IDLE;
            hcnt_n  = '0;
          end else begin
            hcnt_n = hcnt + HW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Line levels for the half-bit that begins next cycle; a freshly popped word is used directly
  always_comb begin
    word_n     = load ? mem[rd_ptr] : word_q;
    first_half = 1'b1;
    bit_val    = 1'b0;
    txp_n      = 1'b0;
    txn_n      = 1'b0;
    case (state_n)
      S_SYNC: begin
        first_half = (hcnt_n < HW'(3));
        txp_n      = ~(word_n[16] ^ first_half);
        txn_n      = ~txp_n;
      end
      S_DATA: begin
        bit_val    = word_n[4'd15 - hcnt_n[4:1]];
        first_half = ~hcnt_n[0];
        txp_n      = ~(bit_val ^ first_half);
        txn_n      = ~txp_n;
      end
      S_PARITY: begin
        bit_val    = ~(^word_n[15:0]);
        first_half = ~hcnt_n[0];
        txp_n      = ~(bit_val ^ first_half);
        txn_n      = ~txp_n;
      end
      default: ;
    endcase
  end

  // FSM state, half-bit divider (restarted on every word load) and registered line outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      div_cnt   <= '0;
      word_q    <= '0;
      pending   <= 1'b0;
      txp       <= 1'b0;
      txn       <= 1'b0;
      tx_en     <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      hcnt      <= hcnt_n;
      div_cnt   <= (load || tick || state_n == S_IDLE) ? '0 : div_cnt + DW'(1);
      if (load) word_q <= word_n;
      if (state == S_IDLE) pending <= 1'b0;
      else if (tx_start)   pending <= 1'b1;
      txp       <= txp_n;
      txn       <= txn_n;
      tx_en     <= (state_n == S_SYNC) || (state_n == S_DATA) || (state_n == S_PARITY);
      busy      <= (state_n != S_IDLE);
      word_done <= done_n;
    end
  end

  // Occupancy after this cycle's accepted write and/or pop
  always_comb begin
    count_n = fifo_count;
    if (wr_ok && !load)      count_n = fifo_count + CW'(1);
    else if (!wr_ok && load) count_n = fifo_count - CW'(1);
  end

  // FIFO storage; contents need no reset because occupancy is cleared
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy flags and overflow pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      ovf        <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (load)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_n;
      fifo_full  <= (count_n == CW'(DEPTH));
      fifo_empty <= (count_n == '0);
      ovf        <= wr_en && !wr_ok;
    end
  end

endmodule

// File: tb/tb_mil_txd_fifo.sv
// tb/tb_mil_txd_fifo.sv - scoreboard bench for mil_txd_fifo
module tb_mil_txd_fifo;

  localparam int DIV       = 25;
  localparam int DEPTH     = 32;
  localparam int WORD_CLKS = 40 * DIV;
  localparam int GAP_CLKS  = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [16:0] wr_data = '0;
  logic        tx_start = 1'b0;
  logic        txp, txn, tx_en, busy, word_done, fifo_full, fifo_empty, ovf;
  logic [5:0]  fifo_count;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  logic [16:0] exp_q[$];
  logic [1:0]  buf_q[$];

  mil_txd_fifo #(.FCLK(50_000_000), .BITRATE(1_000_000), .DEPTH(DEPTH), .GAP_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .tx_start(tx_start),
    .txp(txp), .txn(txn), .tx_en(tx_en), .busy(busy), .word_done(word_done),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected txp level for half-bit h (0..39) of word w; txn is its complement
  function automatic bit exp_txp(input logic [16:0] w, input int h);
    bit b;
    if (h < 6) return (h < 3) == w[16];
    if (h < 38) b = w[15 - (h - 6) / 2];
    else        b = ($countones(w[15:0]) % 2) == 0;
    return (h % 2 == 0) == b;
  endfunction

  // Monitor: collect line samples while tx_en is high, compare whole word on word_done
  logic [16:0] mon_w;
  int          mon_bad;
  bit          mon_p;
  initial forever begin
    @(negedge clk);
    if ((txp && txn) || (!tx_en && (txp || txn))) viol++;
    if (word_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        mon_w = exp_q.pop_front();
        mon_bad = 0;
        check($sformatf("word_len_%05h", mon_w), buf_q.size(), WORD_CLKS);
        for (int h = 0; h < 40; h++) begin
          mon_p = exp_txp(mon_w, h);
          for (int c = 0; c < DIV; c++)
            if (h * DIV + c >= buf_q.size() || buf_q[h * DIV + c] !== {mon_p, ~mon_p}) mon_bad++;
        end
        check($sformatf("word_wave_%05h_bad_samples", mon_w), mon_bad, 0);
      end
      buf_q.delete();
    end
    if (tx_en) buf_q.push_back({txp, txn});
  end

  task automatic do_write(input logic [16:0] d);
    bit acc;
    acc = exp_q.size() < DEPTH;
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_on_write", ovf, !acc);
    if (acc) exp_q.push_back(d);
  endtask

  // Returns on the first sample after the edge that accepted the start
  task automatic pulse_start();
    @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    buf_q.delete();
    @(negedge clk);
    check("rst_txp", txp, 0);
    check("rst_txn", txn, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_fifo_full", fifo_full, 0);
    rst_n = 1'b1;
  endtask

  task automatic run_msg(input int n, input bit extend);
    int t_done[$];
    int t_txen;
    int t_busy;
    int nw;
    t_txen = -1;
    t_busy = -1;
    nw = n + (extend ? 1 : 0);
    pulse_start();
    check("latency_tx_en", tx_en, 1);
    check("latency_busy", busy, 1);
    for (int t = 0; t < nw * WORD_CLKS + GAP_CLKS + 600; t++) begin
      if (t > 0) @(negedge clk);
      if (extend && t == 500) begin
        wr_en = 1'b1;
        wr_data = 17'($urandom);
        exp_q.push_back(wr_data);
      end
      if (extend && t == 501) wr_en = 1'b0;
      if (word_done) t_done.push_back(t);
      if (!tx_en && t_txen < 0) t_txen = t;
      if (!busy) begin
        t_busy = t;
        break;
      end
    end
    check("word_done_count", t_done.size(), nw);
    for (int i = 0; i < nw; i++)
      check($sformatf("word_done_time_%0d", i), (i < t_done.size()) ? t_done[i] : -1, (i + 1) * WORD_CLKS);
    check("tx_en_fall_time", t_txen, nw * WORD_CLKS);
    check("busy_fall_time", t_busy, nw * WORD_CLKS + GAP_CLKS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  int low;
  initial begin
    repeat (2) @(negedge clk);
    check("init_txp", txp, 0);
    check("init_tx_en", tx_en, 0);
    check("init_busy", busy, 0);
    check("init_fifo_empty", fifo_empty, 1);
    check("init_fifo_count", fifo_count, 0);
    rst_n = 1'b1;

    do_write({1'b1, 16'hA5A5});
    check("count_after_write", fifo_count, 1);
    run_msg(1, 1'b0);
    do_write({1'b0, 16'h0001});
    run_msg(1, 1'b0);
    do_write({1'b1, 16'h1234});
    do_write({1'b0, 16'hFFFF});
    do_write({1'b0, 16'h0000});
    run_msg(3, 1'b0);

    repeat (4) begin
      n = $urandom_range(1, 3);
      repeat (n) do_write(17'($urandom));
      run_msg(n, 1'($urandom_range(0, 1)));
    end

    // tx_start during the gap is held and serviced once the gap ends
    do_write({1'b1, 16'h8001});
    pulse_start();
    repeat (1050) @(negedge clk);
    do_write({1'b0, 16'h7FFE});
    pulse_start();
    low = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy) low++;
      if (low > 0 && busy) break;
    end
    check("pending_busy_low_cycles", low, 1);
    for (int t = 0; t < 2000 && busy; t++) @(negedge clk);
    check("pending_done_busy", busy, 0);

    // Fill past capacity: the 33rd write is dropped
    for (int i = 0; i < 33; i++) do_write(17'($urandom));
    check("full_flag", fifo_full, 1);
    check("full_count", fifo_count, 32);

    // Write and pop together while full
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 17'h0BEEF;
    tx_start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    tx_start = 1'b0;
    exp_q.push_back(17'h0BEEF);
    check("full_wr_pop_ovf", ovf, 0);
    check("full_wr_pop_count", fifo_count, 32);
    check("full_wr_pop_busy", busy, 1);

    // Reset in the middle of the data field discards everything
    repeat (300) @(negedge clk);
    apply_reset();
    pulse_start();
    low = 0;
    for (int t = 0; t < 8; t++) begin
      if (busy || tx_en) low++;
      @(negedge clk);
    end
    check("start_after_reset_ignored", low, 0);
    do_write({1'b1, 16'hC3C3});
    run_msg(1, 1'b0);

    check("protocol_violations", viol, 0);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
